// File: rtl/mac_stream_if.sv
`default_nettype none
// ============================================================================
//  Module   : mac_stream_if
//  Brief    : Stream bundle for mac_stream. Operand A and B channels
//             (strobe/acknowledge), the end-of-vector flag, and the result
//             channel with its overflow flag.
//  Revision : 1.0 - initial release
// ============================================================================
interface mac_stream_if #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 40
);
    // Operand A channel
    logic signed [WIDTH-1:0]     input_a;
    logic                        input_a_stb;
    logic                        input_a_ack;

    // Operand B channel, with the end-of-vector flag travelling alongside B
    logic signed [WIDTH-1:0]     input_b;
    logic                        input_b_stb;
    logic                        input_b_ack;
    logic                        input_last;

    // Result channel
    logic signed [ACC_WIDTH-1:0] output_z;
    logic                        output_z_stb;
    logic                        output_z_ack;
    logic                        output_ovf;

    // Producer of operands / consumer of results
    modport master (
        output input_a, input_a_stb, input_b, input_b_stb, input_last, output_z_ack,
        input  input_a_ack, input_b_ack, output_z, output_z_stb, output_ovf
    );

    // The accumulator itself
    modport slave (
        input  input_a, input_a_stb, input_b, input_b_stb, input_last, output_z_ack,
        output input_a_ack, input_b_ack, output_z, output_z_stb, output_ovf
    );
endinterface
`default_nettype wire

// File: rtl/mac_stream.sv
`default_nettype none
// ============================================================================
//  Module   : mac_stream
//  Brief    : Streaming signed multiply-accumulate. Takes A then B, multiplies
//             them at full precision, and adds the product into a wide
//             accumulator. When the B carrying the end-of-vector flag has been
//             accumulated, the result and a sticky overflow flag are offered
//             on the result channel; after it is taken the accumulator clears.
//             Overflow either clamps (SATURATE=1) or wraps (SATURATE=0).
//  Revision : 1.0 - initial release
// ============================================================================
module mac_stream #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 40,
    parameter int SATURATE  = 1
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    mac_stream_if.slave bus
);

    // ------------------------------------------------------------------------
    // Parameter sanity: the accumulator must hold a full product.
    // ------------------------------------------------------------------------
    generate
        if (ACC_WIDTH < 2 * WIDTH) begin : g_bad_acc_width
            $error("mac_stream: ACC_WIDTH (%0d) must be at least 2*WIDTH (%0d)",
                   ACC_WIDTH, 2 * WIDTH);
        end
    endgenerate

    // Number of sign bits needed to lift a product to the widened sum width
    localparam int c_ext = ACC_WIDTH + 1 - 2 * WIDTH;

    // Clamp limits of the accumulator
    localparam logic [ACC_WIDTH-1:0] c_acc_max = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] c_acc_min = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        GET_A = 3'd0,
        GET_B = 3'd1,
        MULT  = 3'd2,
        ACCUM = 3'd3,
        PUT_Z = 3'd4
    } state_t;

    state_t                 r_state;
    logic [WIDTH-1:0]       r_a;
    logic [WIDTH-1:0]       r_b;
    logic                   r_last;
    logic [2*WIDTH-1:0]     r_prod;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic                   r_ovf;

    logic                   r_a_ack;
    logic                   r_b_ack;
    logic                   r_z_stb;
    logic [ACC_WIDTH-1:0]   r_z;
    logic                   r_z_ovf;

    logic [2*WIDTH-1:0]     w_prod;
    logic [ACC_WIDTH:0]     w_prod_ext;
    logic [ACC_WIDTH:0]     w_sum;
    logic                   w_sum_ovf;
    logic [ACC_WIDTH-1:0]   w_acc_next;
    logic                   w_ovf_next;

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    // Both operands are sign-extended to the product width first, so the low
    // 2*WIDTH bits of this unsigned multiply are the exact signed product.
    assign w_prod = {{WIDTH{r_a[WIDTH-1]}}, r_a} * {{WIDTH{r_b[WIDTH-1]}}, r_b};

    // One guard bit above the accumulator: the sum cannot itself overflow,
    // and a mismatch between the top two bits flags accumulator overflow.
    assign w_prod_ext = {{c_ext{r_prod[2*WIDTH-1]}}, r_prod};
    assign w_sum      = {r_acc[ACC_WIDTH-1], r_acc} + w_prod_ext;
    assign w_sum_ovf  = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];
    assign w_ovf_next = r_ovf | w_sum_ovf;

    // Next accumulator value: wrapped low bits, or clamped toward the true sign
    always_comb begin
        w_acc_next = w_sum[ACC_WIDTH-1:0];
        if (w_sum_ovf && (SATURATE != 0)) begin
            w_acc_next = w_sum[ACC_WIDTH] ? c_acc_min : c_acc_max;
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM with registered handshakes and result outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= GET_A;
            r_a     <= '0;
            r_b     <= '0;
            r_last  <= 1'b0;
            r_prod  <= '0;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_a_ack <= 1'b0;
            r_b_ack <= 1'b0;
            r_z_stb <= 1'b0;
            r_z     <= '0;
            r_z_ovf <= 1'b0;
        end else begin
            case (r_state)
                GET_A: begin
                    if (r_a_ack && bus.input_a_stb) begin
                        r_a     <= bus.input_a;
                        r_a_ack <= 1'b0;
                        r_b_ack <= 1'b1;
                        r_state <= GET_B;
                    end else begin
                        // Also raises the ready one edge after reset release
                        r_a_ack <= 1'b1;
                    end
                end

                GET_B: begin
                    if (r_b_ack && bus.input_b_stb) begin
                        r_b     <= bus.input_b;
                        r_last  <= bus.input_last;
                        r_b_ack <= 1'b0;
                        r_state <= MULT;
                    end else begin
                        r_b_ack <= 1'b1;
                    end
                end

                MULT: begin
                    r_prod  <= w_prod;
                    r_state <= ACCUM;
                end

                ACCUM: begin
                    r_acc <= w_acc_next;
                    r_ovf <= w_ovf_next;
                    if (r_last) begin
                        r_z_stb <= 1'b1;
                        r_z     <= w_acc_next;
                        r_z_ovf <= w_ovf_next;
                        r_state <= PUT_Z;
                    end else begin
                        r_a_ack <= 1'b1;
                        r_state <= GET_A;
                    end
                end

                PUT_Z: begin
                    // Result held until taken; then start a fresh vector
                    if (r_z_stb && bus.output_z_ack) begin
                        r_z_stb <= 1'b0;
                        r_z     <= '0;
                        r_z_ovf <= 1'b0;
                        r_acc   <= '0;
                        r_ovf   <= 1'b0;
                        r_a_ack <= 1'b1;
                        r_state <= GET_A;
                    end
                end

                default: begin
                    r_a_ack <= 1'b0;
                    r_b_ack <= 1'b0;
                    r_z_stb <= 1'b0;
                    r_z     <= '0;
                    r_z_ovf <= 1'b0;
                    r_state <= GET_A;
                end
            endcase
        end
    end

    assign bus.input_a_ack  = r_a_ack;
    assign bus.input_b_ack  = r_b_ack;
    assign bus.output_z_stb = r_z_stb;
    assign bus.output_z     = r_z;
    assign bus.output_ovf   = r_z_ovf;

endmodule
`default_nettype wire

// File: doc/mac_stream.md
MAC_STREAM -- requirements
Module: mac_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 16: signed operand width, in bits.
REQ-002 SHALL have parameter ACC_WIDTH, default 40: accumulator and result width; elaboration SHALL fail if ACC_WIDTH < 2*WIDTH.
REQ-003 SHALL have parameter SATURATE, default 1: 1 = clamp on overflow, 0 = two's-complement wrap.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 input_a  input  WIDTH  signed operand A.
REQ-007 input_a_stb  input  1  A valid.
REQ-008 input_a_ack  output  1  A ready; transfer when input_a_stb & input_a_ack at a clock edge.
REQ-009 input_b  input  WIDTH  signed operand B.
REQ-010 input_b_stb  input  1  B valid.
REQ-011 input_b_ack  output  1  B ready; transfer when input_b_stb & input_b_ack.
REQ-012 input_last  input  1  end-of-vector flag, sampled with the B transfer.
REQ-013 output_z  output  ACC_WIDTH  signed accumulated result.
REQ-014 output_z_stb  output  1  result valid.
REQ-015 output_z_ack  input  1  result accepted; transfer when output_z_stb & output_z_ack.
REQ-016 output_ovf  output  1  sticky overflow flag for the current vector, valid with output_z_stb.

Function
REQ-017 FSM states SHALL be GET_A, GET_B, MULT, ACCUM, PUT_Z; one state per cycle except where waiting on a handshake.
REQ-018 GET_A: input_a_ack=1; on A transfer, latch input_a, drop input_a_ack next cycle, go GET_B.
REQ-019 GET_B: input_b_ack=1; on B transfer, latch input_b and input_last, drop input_b_ack next cycle, go MULT.
REQ-020 input_a_ack and input_b_ack SHALL be registered, and never both high in the same cycle.
REQ-021 MULT: product = signed A * signed B, full 2*WIDTH bits, registered; go ACCUM.
REQ-022 ACCUM: sum = acc + sign-extended product, computed at ACC_WIDTH+1 bits; overflow when the sum's top two bits differ.
REQ-023 On overflow with SATURATE=1: acc SHALL clamp to +2^(ACC_WIDTH-1)-1 (positive overflow) or -2^(ACC_WIDTH-1) (negative overflow); with SATURATE=0: acc SHALL take the low ACC_WIDTH bits; in both modes ovf SHALL be set sticky.
REQ-024 ACCUM exit: latched last=1 -> PUT_Z; else -> GET_A with acc retained.
REQ-025 PUT_Z: output_z_stb=1; output_z=acc and output_ovf=ovf SHALL be held stable until output_z_ack.
REQ-026 On Z transfer: drop output_z_stb next cycle, clear acc and ovf to 0, go GET_A.
REQ-027 Latency: A accepted at edge t, B at edge t+1 (earliest) -> output_z_stb high in cycle after edge t+3 for a single-element vector.
REQ-028 Stalls (stb low, or output_z_ack low) SHALL hold all state indefinitely with no data loss.
REQ-029 output_z and output_ovf SHALL be 0 whenever output_z_stb=0.
REQ-030 Stb assertion while the matching ack is low SHALL have no effect.

Reset
REQ-031 At any edge with rst_n=0, in any state (including mid-vector or in PUT_Z): state<=GET_A, acc<=0, ovf<=0, all operand latches<=0, and all outputs<=0 (input_a_ack, input_b_ack, output_z_stb, output_z, output_ovf).
REQ-032 input_a_ack SHALL rise at the first edge with rst_n=1; an in-flight vector SHALL be discarded.

Verification
REQ-033 Single element, WIDTH=16: A=3, B=-4, last=1 -> output_z=-12, output_ovf=0, output_z_stb exactly 3 cycles after B accept.
REQ-034 Vector: (2,5), (-3,7), (10,10) with last on the third -> one result only, output_z=89, ovf=0; acc cleared after ack.
REQ-035 Saturation, WIDTH=8, ACC_WIDTH=16, SATURATE=1: three (127,127) pairs -> output_z=32767, output_ovf=1; next vector (1,1,last) -> output_z=1, output_ovf=0.
REQ-036 Wrap, same widths, SATURATE=0: three (127,127) pairs -> output_z=-17149, output_ovf=1.
REQ-037 Backpressure: output_z_ack held low 10 cycles -> output_z and stb stable, input_a_ack=0 throughout; accepted on the cycle ack rises.
REQ-038 Reset mid-vector: after two pairs (5,5), assert rst_n=0 for 1 cycle, then (1,2,last) -> output_z=2, output_ovf=0.
